// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 slave backed by a 128-bit word array. It serves one
// INCR burst at a time (read or write, up to 256 beats) and arbitrates AR/AW
// with alternating priority.
// Latency: read data appears RD_LAT+1 cycles after the AR handshake cycle. Write
// beats are accepted back to back, and B follows the last beat by one cycle.
// Backpressure: R holds data stable until rready is seen. B holds until bready.
// Optional stall source: define AXI_SLV_BP_EN to enable an LFSR that randomly
// drops wready and delays presentation of new read beats.
// Ports: clk/rst_n (async active-low). AW/W/B and AR/R channels use the
// *_s_inf names, 128-bit data and ID_W-bit IDs.

module axi4_mem_responder #(
   parameter int DEPTH  = 8192,
   parameter int RD_LAT = 2,
   parameter int ID_W   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ID_W-1:0] awid_s_inf,
   input  logic [31:0]     awaddr_s_inf,
   input  logic [2:0]      awsize_s_inf,
   input  logic [1:0]      awburst_s_inf,
   input  logic [7:0]      awlen_s_inf,
   input  logic            awvalid_s_inf,
   output logic            awready_s_inf,
   input  logic [127:0]    wdata_s_inf,
   input  logic            wlast_s_inf,
   input  logic            wvalid_s_inf,
   output logic            wready_s_inf,
   output logic [ID_W-1:0] bid_s_inf,
   output logic [1:0]      bresp_s_inf,
   output logic            bvalid_s_inf,
   input  logic            bready_s_inf,
   input  logic [ID_W-1:0] arid_s_inf,
   input  logic [31:0]     araddr_s_inf,
   input  logic [7:0]      arlen_s_inf,
   input  logic [2:0]      arsize_s_inf,
   input  logic [1:0]      arburst_s_inf,
   input  logic            arvalid_s_inf,
   output logic            arready_s_inf,
   output logic [ID_W-1:0] rid_s_inf,
   output logic [127:0]    rdata_s_inf,
   output logic [1:0]      rresp_s_inf,
   output logic            rlast_s_inf,
   output logic            rvalid_s_inf,
   input  logic            rready_s_inf
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [1:0]  OKAY      = 2'b00;
   localparam logic [1:0]  SLVERR    = 2'b10;
   localparam logic [3:0]  WAIT_LAST = 4'((RD_LAT > 0) ? RD_LAT - 1 : 0);
   localparam logic [28:0] WORDS     = 29'(DEPTH);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_AR_ACC  = 3'd1;
   localparam logic [2:0] S_RD_WAIT = 3'd2;
   localparam logic [2:0] S_RD_BEAT = 3'd3;
   localparam logic [2:0] S_AW_ACC  = 3'd4;
   localparam logic [2:0] S_WR_BEAT = 3'd5;
   localparam logic [2:0] S_WR_RESP = 3'd6;

   logic [127:0] mem [DEPTH];

   logic [2:0]  state;
   logic [27:0] base;        // burst start as a 16-byte word address
   logic [7:0]  len;
   logic [7:0]  beat;        // read: next beat to present; write: current beat
   logic [3:0]  wait_cnt;
   logic        burst_err;   // illegal size/burst: every beat errors, no writes
   logic        wr_err;
   logic        prefer_wr;   // tie-break owner when AR and AW are both pending
   logic        stall;

   logic unused_bits;
   assign unused_bits = ^{awaddr_s_inf[3:0], araddr_s_inf[3:0]};

`ifdef AXI_SLV_BP_EN
   logic [15:0] lfsr;
   // Fibonacci LFSR, taps 16,14,13,11.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 16'hACE1;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   // Handshake outputs are decoded straight from the registered state so reset
   // forces them low immediately.
   assign arready_s_inf = (state == S_AR_ACC);
   assign awready_s_inf = (state == S_AW_ACC);
   assign wready_s_inf  = (state == S_WR_BEAT) && !stall;
   assign bvalid_s_inf  = (state == S_WR_RESP);

   // Read beat loader. While in AR_ACC the burst fields are not latched yet, so
   // they are taken from the AR channel directly (needed when RD_LAT is 0).
   logic [27:0] ld_base;
   logic [7:0]  ld_beat;
   logic [7:0]  ld_len;
   logic        ld_err;
   logic [28:0] ld_word;
   logic        ld_oor;
   logic        rd_enter;
   logic        rd_load;

   always_comb begin
      ld_base = base;
      ld_beat = beat;
      ld_len  = len;
      ld_err  = burst_err;
      if (state == S_AR_ACC) begin
         ld_base = araddr_s_inf[31:4];
         ld_beat = 8'd0;
         ld_len  = arlen_s_inf;
         ld_err  = (arsize_s_inf != 3'b100) || (arburst_s_inf != 2'b01);
      end
   end

   // One extra bit so a burst running off the top of the 32-bit space does not
   // wrap back into the array.
   assign ld_word  = {1'b0, ld_base} + {21'd0, ld_beat};
   assign ld_oor   = (ld_word >= WORDS);
   assign rd_enter = ((state == S_AR_ACC) && (RD_LAT == 0)) ||
                     ((state == S_RD_WAIT) && (wait_cnt == WAIT_LAST));
   // A new beat is presented on entry, after a stalled gap, or right after a
   // non-final handshake. A beat already on the bus is never replaced early.
   assign rd_load  = !stall && (rd_enter ||
                     ((state == S_RD_BEAT) &&
                      (!rvalid_s_inf || (rready_s_inf && !rlast_s_inf))));

   // Write beat evaluation.
   logic [28:0] wr_word;
   logic        wr_oor;
   logic        wr_hs;
   logic        wr_end;
   logic        wr_bad;

   assign wr_word = {1'b0, base} + {21'd0, beat};
   assign wr_oor  = (wr_word >= WORDS);
   assign wr_hs   = wready_s_inf && wvalid_s_inf;
   assign wr_end  = wlast_s_inf || (beat == len);
   assign wr_bad  = wr_oor || (wlast_s_inf != (beat == len));

   // Array is deliberately left unreset: a reset mid-burst keeps earlier beats.
   always_ff @(posedge clk) begin
      if (wr_hs && !burst_err && !wr_oor)
         mem[wr_word[AW-1:0]] <= wdata_s_inf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         base        <= '0;
         len         <= '0;
         beat        <= '0;
         wait_cnt    <= '0;
         burst_err   <= 1'b0;
         wr_err      <= 1'b0;
         prefer_wr   <= 1'b0;
         bid_s_inf   <= '0;
         bresp_s_inf <= OKAY;
         rid_s_inf   <= '0;
         rdata_s_inf <= '0;
         rresp_s_inf <= OKAY;
         rlast_s_inf <= 1'b0;
         rvalid_s_inf <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (arvalid_s_inf && (!awvalid_s_inf || !prefer_wr)) begin
                  state <= S_AR_ACC;
                  if (awvalid_s_inf) prefer_wr <= 1'b1;
               end else if (awvalid_s_inf) begin
                  state <= S_AW_ACC;
                  if (arvalid_s_inf) prefer_wr <= 1'b0;
               end
            end
            S_AR_ACC: begin
               rid_s_inf <= arid_s_inf;
               base      <= araddr_s_inf[31:4];
               len       <= arlen_s_inf;
               burst_err <= (arsize_s_inf != 3'b100) || (arburst_s_inf != 2'b01);
               beat      <= 8'd0;
               wait_cnt  <= 4'd0;
               state     <= (RD_LAT == 0) ? S_RD_BEAT : S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (wait_cnt == WAIT_LAST) state <= S_RD_BEAT;
               else                       wait_cnt <= wait_cnt + 4'd1;
            end
            S_RD_BEAT: begin
               if (rvalid_s_inf && rready_s_inf && rlast_s_inf) state <= S_IDLE;
            end
            S_AW_ACC: begin
               bid_s_inf <= awid_s_inf;
               base      <= awaddr_s_inf[31:4];
               len       <= awlen_s_inf;
               burst_err <= (awsize_s_inf != 3'b100) || (awburst_s_inf != 2'b01);
               beat      <= 8'd0;
               wr_err    <= 1'b0;
               state     <= S_WR_BEAT;
            end
            S_WR_BEAT: begin
               if (wr_hs) begin
                  beat <= beat + 8'd1;
                  if (wr_bad) wr_err <= 1'b1;
                  // Burst closes on the first wlast or on beat len, whichever
                  // arrives first. Any mismatch between the two is an error.
                  if (wr_end) begin
                     state       <= S_WR_RESP;
                     bresp_s_inf <= (burst_err || wr_err || wr_bad) ? SLVERR : OKAY;
                  end
               end
            end
            S_WR_RESP: begin
               if (bready_s_inf) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // Read data path. It sits after the case so that a load in AR_ACC
         // (RD_LAT of 0) overrides the beat clear issued there.
         if (rd_load) begin
            rdata_s_inf  <= (ld_oor || ld_err) ? '0 : mem[ld_word[AW-1:0]];
            rresp_s_inf  <= (ld_oor || ld_err) ? SLVERR : OKAY;
            rlast_s_inf  <= (ld_beat == ld_len);
            rvalid_s_inf <= 1'b1;
            beat         <= ld_beat + 8'd1;
         end else if (rvalid_s_inf && rready_s_inf) begin
            rvalid_s_inf <= 1'b0;
            rlast_s_inf  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/axi4_mem_responder.md
Name: axi4_mem_responder

Overview:
- Synthesizable AXI4 slave memory. It is the responder end of the 128-bit AXI interface the ISP drives as master.
- Replaces the behavioural DRAM model in gate-level and emulation benches.
- Backed by an internal 128-bit word array.
- Serves one read or write burst at a time. Supports INCR bursts of up to 256 beats.

Parameters:
- DEPTH, 8192, number of 128-bit words; power of two.
- RD_LAT, 2, idle cycles between the AR handshake and the first rvalid; range 0..15.
- ID_W, 4, width of all ID fields.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- awid_s_inf  in  ID_W  write ID
- awaddr_s_inf  in  32  write byte address
- awsize_s_inf  in  3  beat size; must be 3'b100
- awburst_s_inf  in  2  burst type; must be 2'b01 (INCR)
- awlen_s_inf  in  8  beats minus 1
- awvalid_s_inf  in  1  write address valid
- awready_s_inf  out  1  write address ready
- wdata_s_inf  in  128  write data
- wlast_s_inf  in  1  last write beat
- wvalid_s_inf  in  1  write data valid
- wready_s_inf  out  1  write data ready
- bid_s_inf  out  ID_W  response ID (echoes awid)
- bresp_s_inf  out  2  write response
- bvalid_s_inf  out  1  write response valid
- bready_s_inf  in  1  write response ready
- arid_s_inf  in  ID_W  read ID
- araddr_s_inf  in  32  read byte address
- arlen_s_inf  in  8  beats minus 1
- arsize_s_inf  in  3  beat size
- arburst_s_inf  in  2  burst type
- arvalid_s_inf  in  1  read address valid
- arready_s_inf  out  1  read address ready
- rid_s_inf  out  ID_W  read ID (echoes arid)
- rdata_s_inf  out  128  read data
- rresp_s_inf  out  2  read response
- rlast_s_inf  out  1  last read beat
- rvalid_s_inf  out  1  read data valid
- rready_s_inf  in  1  read data ready

Behaviour:

Reset:
- All outputs are driven to 0 and the FSM goes to IDLE.
- Memory array is not reset.
- Reset asserted mid-burst aborts the burst. No response is issued for it. Beats already written stay in memory.

States and transitions:
- IDLE: all ready/valid outputs low.
  - If arvalid and awvalid are both high, the grant alternates, starting with read after reset.
  - If only one is high, that channel is granted.
  - Next state: AR_ACC or AW_ACC.
- AR_ACC: arready=1 for exactly one cycle. Latch id, addr, len; evaluate errors. Go to RD_WAIT.
- RD_WAIT: count RD_LAT cycles, then RD_BEAT. With RD_LAT=0, go straight to RD_BEAT.
- RD_BEAT:
  - rvalid=1; rdata, rresp, rlast are registered.
  - rdata/rresp/rlast/rid hold stable until rvalid && rready.
  - On each handshake the beat counter increments.
  - rlast=1 on beat len. After its handshake, return to IDLE.
- AW_ACC: awready=1 for exactly one cycle. Latch id, addr, len. Go to WR_BEAT.
- WR_BEAT:
  - wready=1; each wvalid && wready writes wdata to memory.
  - wlast is checked on every beat:
    - wlast early (before beat len) or missing on beat len: bresp=SLVERR. The burst ends on the first wlast or after beat len, whichever comes first.
  - Then go to WR_RESP.
- WR_RESP: bvalid=1, bid=latched id, bresp held until bready. Then IDLE.

Addressing:
- Word index = addr[log2(DEPTH)+3:4]; addr[3:0] is ignored.
- Beat k uses index base+k. There is no wrap and no 4KB check.
- A beat whose byte address is at or above DEPTH*16:
  - read: rdata=0, rresp=2'b10 (SLVERR)
  - write: dropped, and the burst's bresp=SLVERR

Errors:
- size != 3'b100 or burst != 2'b01: every beat returns SLVERR, no memory write. The handshake still completes for full len+1 beats.
- OKAY = 2'b00.

Read data:
- Read data reflects all write beats handshaken before the AR handshake.

Optional Feature:
- Macro: AXI_SLV_BP_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
  - When LFSR bit0 is 1, wready is deasserted in WR_BEAT and rvalid is withheld before presenting a new beat in RD_BEAT.
  - A beat already presented (rvalid high) is never withdrawn.
- Undefined: no stalls. Ready/valid follow the states above exactly.

Test Plan:
1. Write addr 0x100, len 3, data 1..4 → 4 beats accepted on consecutive cycles, bresp 00, bid = awid. Then read addr 0x100, len 3 (RD_LAT=2) → first rvalid 3 cycles after arready, rdata 1,2,3,4, rlast on beat 4 only.
2. Read with rready toggling 1,0,0,1 → rdata/rlast held stable while rready=0; no beat lost or duplicated.
3. arvalid and awvalid both high from IDLE on three consecutive transactions → grant order read, write, read.
4. Read addr DEPTH*16-32, len 3 → beats 0-1 OKAY with stored data; beats 2-3 rdata 0, rresp 10.
5. Write len 3 with wlast on beat 2 → burst ends, bresp 10. Write with awburst 2'b10 → 1+len beats consumed, memory unchanged, bresp 10.
6. Assert rst_n low during beat 2 of a 16-beat read → all outputs 0 immediately. Next read after reset completes normally with correct data.
